// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one SRAM-like request per instruction, decode-stall
// buffering and flush drop. Optional misaligned-fetch exception via FETCH_ADEL_EN.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        id_stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid,
    output logic        fetch_stall,
    output logic        adel_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state, state_n;
    logic        req_first;
    logic        drop_q;
    logic        hold_adel;
    logic        adel_req;
    logic        complete;
    logic        done_adel;
    logic [31:0] addr_q;
    logic [31:0] buf_q;
    logic [31:0] cur_addr;
    logic [31:0] done_inst;
    logic [31:0] done_pc;

`ifdef FETCH_ADEL_EN
    assign adel_req = (state == S_REQ) && req_first && (pc[1:0] != 2'b00);
    assign cur_addr = req_first ? pc : addr_q;
`else
    logic unused_pc;
    assign unused_pc = ^pc[1:0];
    assign adel_req  = 1'b0;
    assign cur_addr  = req_first ? {pc[31:2], 2'b00} : addr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_REQ: begin
                if (adel_req) begin
                    if (!flush && id_stall) state_n = S_HOLD;
                end else if (inst_addr_ok) begin
                    state_n = (flush || drop_q) ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok)
                    state_n = (!flush && id_stall) ? S_HOLD : S_REQ;
                else if (flush)
                    state_n = S_DROP;
            end
            S_HOLD: if (flush || !id_stall) state_n = S_REQ;
            S_DROP: if (inst_data_ok) state_n = S_REQ;
            default: state_n = S_REQ;
        endcase
    end

    always_comb begin
        inst_req  = 1'b0;
        inst_addr = addr_q;
        complete  = 1'b0;
        done_inst = inst_rdata;
        done_pc   = addr_q;
        done_adel = 1'b0;
        case (state)
            S_REQ: begin
                inst_req  = !adel_req;
                inst_addr = cur_addr;
                complete  = adel_req && !id_stall && !flush;
                done_inst = 32'h0;
                done_pc   = pc;
                done_adel = 1'b1;
            end
            S_WAIT: complete = inst_data_ok && !id_stall && !flush;
            S_HOLD: begin
                complete  = !id_stall && !flush;
                done_inst = buf_q;
                done_adel = hold_adel;
            end
            default: ;
        endcase
        fetch_stall = ~complete;
    end

    // addr_q follows the live PC only on the first REQ cycle, then holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_first  <= 1'b1;
            drop_q     <= 1'b0;
            addr_q     <= RESET_PC;
            buf_q      <= 32'h0;
            hold_adel  <= 1'b0;
            inst_o     <= 32'h0;
            pc_o       <= RESET_PC;
            inst_valid <= 1'b0;
            adel_o     <= 1'b0;
        end else begin
            req_first <= (state != S_REQ) || adel_req;
            drop_q    <= (state == S_REQ) && !inst_addr_ok && !adel_req
                         && (drop_q || flush);
            if (state == S_REQ) addr_q <= cur_addr;
            if (state == S_WAIT && inst_data_ok && id_stall && !flush) begin
                buf_q     <= inst_rdata;
                hold_adel <= 1'b0;
            end else if (adel_req && id_stall && !flush) begin
                buf_q     <= 32'h0;
                hold_adel <= 1'b1;
            end
            if (complete) begin
                inst_o     <= done_inst;
                pc_o       <= done_pc;
                adel_o     <= done_adel;
                inst_valid <= 1'b1;
            end else if (flush || !id_stall || state == S_DROP) begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule
